// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared types and constants for the register-dump UART reader.
// Holds FSM encodings, UART frame constants, header tag and bit-timer width helper.
package reg_dump_pkg;

    localparam int         UART_FRAME_BITS = 10;
    localparam int         BYTES_PER_WORD  = 4;
    localparam logic [2:0] HDR_TAG         = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_XMIT
    } dump_state_t;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    function automatic int timer_w(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/reg_dump_tx_uart.sv
// uart_tx_byte: 8N1 byte transmitter, LSB first, CLK_DIV clocks per bit.
// Ports: clk, rst (async high), i_valid/i_data/o_ready byte handshake, o_tx line.
module uart_tx_byte
    import reg_dump_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int             TW        = timer_w(CLK_DIV);
    localparam logic [TW-1:0]  BIT_END   = TW'(CLK_DIV - 1);
    localparam logic [2:0]     LAST_DATA = 3'(UART_FRAME_BITS - 3);

    uart_state_t   r_state;
    logic [TW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_bit_end;

    assign w_bit_end = (r_cnt == BIT_END);
    assign o_ready   = (r_state == U_IDLE);
    assign o_tx      = r_tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= U_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            // Timer restarts on every bit boundary so bytes never drift.
            if (r_state == U_IDLE || w_bit_end)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + TW'(1);
            case (r_state)
                U_IDLE: begin
                    if (i_valid) begin
                        r_shift <= i_data;
                        r_tx    <= 1'b0;
                        r_state <= U_START;
                    end
                end
                U_START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_bit   <= '0;
                        r_state <= U_DATA;
                    end
                end
                U_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == LAST_DATA) begin
                            r_tx    <= 1'b1;
                            r_state <= U_STOP;
                        end else begin
                            r_tx    <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end
                end
                U_STOP: begin
                    if (w_bit_end)
                        r_state <= U_IDLE;
                end
                default: r_state <= U_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/reg_dump_tx.sv
// reg_dump_tx: walks regs FIRST_REG..LAST_REG, sends each word MSB byte first over UART.
// Ports: clk, rst, start, dbgReg/dbgContent debug port, tx, busy, done. Macro REG_DUMP_HDR_EN adds a header byte.
module reg_dump_tx
    import reg_dump_pkg::*;
#(
    parameter int CLK_DIV   = 868,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  dbgReg,
    input  logic [31:0] dbgContent,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'(LAST_REG);

    dump_state_t r_state;
    logic [31:0] r_word;
    logic [2:0]  r_byte_idx;
    logic        w_ready;
    logic        w_valid;
    logic [7:0]  w_byte;
    logic [2:0]  w_idx_nxt;

    assign w_idx_nxt = r_byte_idx - 3'd1;

    // The first byte of a word is offered straight from dbgContent in LOAD,
    // so START begins on the same edge that snapshots the word.
    always_comb begin
        w_valid = 1'b0;
        w_byte  = r_word[{w_idx_nxt[1:0], 3'b000} +: 8];
        if (r_state == S_LOAD) begin
            w_valid = 1'b1;
`ifdef REG_DUMP_HDR_EN
            w_byte  = {HDR_TAG, dbgReg};
`else
            w_byte  = dbgContent[31:24];
`endif
        end else if (r_state == S_XMIT && w_ready && r_byte_idx != 3'd0) begin
            w_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_word     <= '0;
            r_byte_idx <= '0;
            dbgReg     <= FIRST;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    dbgReg <= FIRST;
                    if (start) begin
                        busy    <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_word     <= dbgContent;
`ifdef REG_DUMP_HDR_EN
                    r_byte_idx <= 3'(BYTES_PER_WORD);
`else
                    r_byte_idx <= 3'(BYTES_PER_WORD - 1);
`endif
                    r_state    <= S_XMIT;
                end
                S_XMIT: begin
                    // The ready cycle is the single idle-high gap between bytes.
                    if (w_ready) begin
                        if (r_byte_idx != 3'd0) begin
                            r_byte_idx <= w_idx_nxt;
                        end else if (dbgReg == LAST) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            dbgReg  <= dbgReg + 5'd1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_uart (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_valid),
        .i_data  (w_byte),
        .o_ready (w_ready),
        .o_tx    (tx)
    );

endmodule

// File: tb/tb_reg_dump_tx.sv
// tb_reg_dump_tx: three reg_dump_tx instances (0..31, 5..5, 2..2) at CLK_DIV=4.
// UART receivers decode tx lines; byte expectations come from a literal table.
module tb_reg_dump_tx;

`ifdef REG_DUMP_HDR_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic clk, rst;
    logic start_a, start_b, start_c;
    logic [4:0] dbg_a, dbg_b, dbg_c;
    logic [31:0] cont_a, cont_b, cont_c;
    logic tx_a, tx_b, tx_c;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;

    logic [31:0] rf [32];
    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    logic [7:0] q_c [$];
    int checks, errors, ferr, rst_gen;
    int dcnt_a, dcnt_b, dcnt_c;

    typedef struct {
        string      name;
        int         sel;
        int         idx;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [$];

    assign cont_a = rf[dbg_a];
    assign cont_b = 32'h11110000 | {27'd0, dbg_b};
    assign cont_c = 32'h11110000 | {27'd0, dbg_c};

    reg_dump_tx #(.CLK_DIV(4), .FIRST_REG(0), .LAST_REG(31)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .dbgReg(dbg_a),
        .dbgContent(cont_a), .tx(tx_a), .busy(busy_a), .done(done_a));
    reg_dump_tx #(.CLK_DIV(4), .FIRST_REG(5), .LAST_REG(5)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .dbgReg(dbg_b),
        .dbgContent(cont_b), .tx(tx_b), .busy(busy_b), .done(done_b));
    reg_dump_tx #(.CLK_DIV(4), .FIRST_REG(2), .LAST_REG(2)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .dbgReg(dbg_c),
        .dbgContent(cont_c), .tx(tx_c), .busy(busy_c), .done(done_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (done_a) dcnt_a++;
        if (done_b) dcnt_b++;
        if (done_c) dcnt_c++;
    end

    function automatic logic tx_of(input int sel);
        case (sel)
            0: return tx_a;
            1: return tx_b;
            default: return tx_c;
        endcase
    endfunction

    task automatic push(input int sel, input logic [7:0] b);
        case (sel)
            0: q_a.push_back(b);
            1: q_b.push_back(b);
            default: q_c.push_back(b);
        endcase
    endtask

    function automatic logic [8:0] get_byte(input int sel, input int idx);
        case (sel)
            0: return (idx < q_a.size()) ? {1'b1, q_a[idx]} : 9'h0;
            1: return (idx < q_b.size()) ? {1'b1, q_b[idx]} : 9'h0;
            default: return (idx < q_c.size()) ? {1'b1, q_c[idx]} : 9'h0;
        endcase
    endfunction

    // Edges land on posedge; sampling on negedge keeps a half-cycle margin.
    task automatic rx(input int sel);
        logic [7:0] b;
        int g;
        forever begin
            @(negedge clk);
            if (tx_of(sel) == 1'b0 && !rst) begin
                g = rst_gen;
                @(negedge clk);
                if (tx_of(sel) != 1'b0) ferr++;
                repeat (2) @(negedge clk);
                if (tx_of(sel) != 1'b0) ferr++;
                for (int i = 0; i < 8; i++) begin
                    repeat ((i == 0) ? 2 : 4) @(negedge clk);
                    b[i] = tx_of(sel);
                end
                repeat (4) @(negedge clk);
                if (tx_of(sel) != 1'b1) ferr++;
                if (g == rst_gen) push(sel, b);
            end
        end
    endtask

    initial begin
        fork
            rx(0);
            rx(1);
            rx(2);
        join_none
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input int s, input int base,
                       input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3,
                       input logic [7:0] b4);
        logic [7:0] bs [5];
        vec_t v;
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3; bs[4] = b4;
        for (int i = 0; i < NB; i++) begin
            v.name = n;
            v.sel  = s;
            v.idx  = base + i;
            v.exp  = bs[i];
            tbl.push_back(v);
        end
    endtask

    task automatic pulse(input int sel);
        @(posedge clk); #1;
        case (sel)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    int n, base5, sz;
    logic [7:0] exp5 [5];

    initial begin
        checks = 0; errors = 0; ferr = 0; rst_gen = 0;
        dcnt_a = 0; dcnt_b = 0; dcnt_c = 0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h11110000 + i;

`ifdef REG_DUMP_HDR_EN
        add("a_first", 0, 0,   8'hA0, 8'h11, 8'h11, 8'h00, 8'h00);
        add("a_w7",    0, 35,  8'hA7, 8'h11, 8'h11, 8'h00, 8'h07);
        add("a_last",  0, 155, 8'hBF, 8'h11, 8'h11, 8'h00, 8'h1F);
        add("b_word",  1, 0,   8'hA5, 8'h11, 8'h11, 8'h00, 8'h05);
        add("c_word",  2, 0,   8'hA2, 8'h11, 8'h11, 8'h00, 8'h02);
        exp5[0] = 8'hA0; exp5[1] = 8'h11; exp5[2] = 8'h11;
        exp5[3] = 8'h00; exp5[4] = 8'h00;
`else
        add("a_first", 0, 0,   8'h11, 8'h11, 8'h00, 8'h00, 8'h00);
        add("a_w7",    0, 28,  8'h11, 8'h11, 8'h00, 8'h07, 8'h00);
        add("a_last",  0, 124, 8'h11, 8'h11, 8'h00, 8'h1F, 8'h00);
        add("b_word",  1, 0,   8'h11, 8'h11, 8'h00, 8'h05, 8'h00);
        add("c_word",  2, 0,   8'h11, 8'h11, 8'h00, 8'h02, 8'h00);
        exp5[0] = 8'h11; exp5[1] = 8'h11; exp5[2] = 8'h00;
        exp5[3] = 8'h00; exp5[4] = 8'h00;
`endif

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'd0, tx_a}, 32'd1);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_dbg_a", {27'd0, dbg_a}, 32'd0);
        chk("rst_dbg_b", {27'd0, dbg_b}, 32'd5);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single-register dump: latency to tx fall and to done.
        #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        chk("b_busy_rise", {31'd0, busy_b}, 32'd1);
        chk("b_tx_still_hi", {31'd0, tx_b}, 32'd1);
        @(posedge clk); #1;
        chk("b_tx_fall", {31'd0, tx_b}, 32'd0);
        chk("b_dbg", {27'd0, dbg_b}, 32'd5);
        n = 0;
        while (!done_b && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("b_done_latency", n, NB * 41);
        chk("b_busy_at_done", {31'd0, busy_b}, 32'd0);
        @(posedge clk); #1;
        chk("b_done_pulse", {31'd0, done_b}, 32'd0);
        repeat (20) @(posedge clk);
        chk("b_nbytes", q_b.size(), NB);

        // Full dump with start spam and a mid-word register write.
        pulse(0);
        for (int i = 0; i < 6; i++) begin
            repeat (96) @(posedge clk);
            pulse(0);
        end
        n = 0;
        while (dbg_a != 5'd7 && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        chk("a_reach_w7", {27'd0, dbg_a}, 32'd7);
        repeat (20) @(posedge clk);
        rf[7] = 32'hDEADBEEF;
        n = 0;
        while (!done_a && n < 20000) begin
            @(posedge clk); #1; n++;
        end
        chk("a_done_seen", {31'd0, done_a}, 32'd1);
        repeat (60) @(posedge clk); #1;
        rf[7] = 32'h11110007;
        chk("a_busy_after", {31'd0, busy_a}, 32'd0);
        chk("a_nbytes", q_a.size(), 32 * NB);
        sz = q_a.size();
        repeat (200) @(posedge clk);
        chk("a_no_extra", q_a.size(), sz);
        chk("a_done_count", dcnt_a, 1);

        // Third instance (header word in the header build).
        pulse(2);
        n = 0;
        while (!done_c && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("c_done_seen", {31'd0, done_c}, 32'd1);
        repeat (20) @(posedge clk);
        chk("c_nbytes", q_c.size(), NB);
        chk("c_done_count", dcnt_c, 1);

        foreach (tbl[k])
            chk($sformatf("%s_%0d", tbl[k].name, tbl[k].idx),
                {23'd0, get_byte(tbl[k].sel, tbl[k].idx)},
                {23'd0, 1'b1, tbl[k].exp});

        // Async reset in the middle of word 3, then a fresh dump.
        base5 = q_a.size();
        pulse(0);
        n = 0;
        while (q_a.size() < base5 + 3 * NB + NB - 3 && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        repeat (15) @(posedge clk);
        chk("r_mid_busy", {31'd0, busy_a}, 32'd1);
        chk("r_mid_dbg", {27'd0, dbg_a}, 32'd3);
        @(negedge clk);
        #2;
        rst_gen++;
        rst = 1'b1;
        #1;
        chk("r_tx", {31'd0, tx_a}, 32'd1);
        chk("r_busy", {31'd0, busy_a}, 32'd0);
        chk("r_dbg", {27'd0, dbg_a}, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (50) @(posedge clk);
        base5 = q_a.size();
        pulse(0);
        n = 0;
        while (q_a.size() < base5 + NB && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < NB; i++)
            chk($sformatf("redump_%0d", i),
                {23'd0, get_byte(0, base5 + i)},
                {23'd0, 1'b1, exp5[i]});
        chk("frame_errors", ferr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
